// File: rtl/seq_div_4bit.sv
// Sequential unsigned restoring divider: one shift-subtract step per clock behind a start/done handshake.
// state  | meaning
// IDLE   | waiting for start; operands latched on acceptance
// RUN    | WIDTH shift-subtract iterations
// DONE   | one-cycle done pulse with q/r/dbz valid
module seq_div_4bit #(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_q,
    output logic [WIDTH-1:0] o_r,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_dbz
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH:0]   r_p;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_r;
    logic             r_busy;
    logic             r_done;
    logic             r_dbz;

    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH:0]   w_p_next;
    logic [WIDTH-1:0] w_a_next;

    // Trial subtract as add of inverted divisor with carry-in 1; bit WIDTH set means borrow.
    assign w_shift  = {r_p[WIDTH-1:0], r_a[WIDTH-1]};
    assign w_trial  = w_shift + ~{1'b0, r_d} + {{WIDTH{1'b0}}, 1'b1};
    assign w_p_next = w_trial[WIDTH] ? w_shift : w_trial;
    assign w_a_next = {r_a[WIDTH-2:0], ~w_trial[WIDTH]};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_d     <= '0;
            r_p     <= '0;
            r_cnt   <= '0;
            r_q     <= '0;
            r_r     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dbz   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_busy <= 1'b1;
                        if (i_b != '0) begin
                            r_a     <= i_a;
                            r_d     <= i_b;
                            r_p     <= '0;
                            r_cnt   <= CW'(WIDTH);
                            r_state <= S_RUN;
                        end else begin
                            r_q     <= '1;
                            r_r     <= i_a;
                            r_dbz   <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_RUN: begin
                    r_p   <= w_p_next;
                    r_a   <= w_a_next;
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_q     <= w_a_next;
                        r_r     <= w_p_next[WIDTH-1:0];
                        r_dbz   <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_q    = r_q;
    assign o_r    = r_r;
    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_dbz  = r_dbz;

endmodule

// File: tb/tb_seq_div_4bit.sv
// Directed bench for seq_div_4bit: handshake timing, divide-by-zero, abort on reset, exhaustive operands.
module tb_seq_div_4bit;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] q;
    logic [3:0] r;
    logic       busy;
    logic       done;
    logic       dbz;

    int tests = 0;
    int fails = 0;

    seq_div_4bit #(.WIDTH(4)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_start(start),
        .i_a    (a),
        .i_b    (b),
        .o_q    (q),
        .o_r    (r),
        .o_busy (busy),
        .o_done (done),
        .o_dbz  (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running, expected to finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Issue one division at the current cycle and follow it back to IDLE.
    task automatic do_div(input logic [3:0] av, input logic [3:0] bv, input string tag);
        logic [3:0] eq;
        logic [3:0] er;
        logic       ed;
        int         lat;
        int         n;
        logic       busy_ok;
        if (bv == 4'd0) begin
            eq = 4'hF; er = av; ed = 1'b1; lat = 0;
        end else begin
            eq = av / bv; er = av % bv; ed = 1'b0; lat = 4;
        end
        a = av; b = bv; start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, " busy_after_start"}, busy, 1);
        n = 0;
        busy_ok = 1'b1;
        while (done !== 1'b1 && n < 10) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            tick();
            n++;
        end
        chk({tag, " latency"}, n, lat);
        chk({tag, " busy_held"}, busy_ok, 1);
        chk({tag, " busy_in_done"}, busy, 1);
        chk({tag, " q"}, q, eq);
        chk({tag, " r"}, r, er);
        chk({tag, " dbz"}, dbz, ed);
        tick();
        chk({tag, " done_single"}, done, 0);
        chk({tag, " idle"}, busy, 0);
        chk({tag, " q_held"}, q, eq);
        chk({tag, " r_held"}, r, er);
    endtask

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; a = 4'd0; b = 4'd0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset q", q, 0);
        chk("reset r", r, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset dbz", dbz, 0);

        do_div(4'd13, 4'd3, "13/3");

        do_div(4'd15, 4'd1, "15/1");
        do_div(4'd7, 4'd9, "7/9");
        do_div(4'd0, 4'd5, "0/5");

        do_div(4'd9, 4'd0, "9/0");
        do_div(4'd6, 4'd2, "6/2");

        // start held high; operands wander while busy
        a = 4'd12; b = 4'd5; start = 1'b1;
        tick();
        chk("hold accept busy", busy, 1);
        for (int k = 1; k <= 4; k++) begin
            a = 4'(k); b = 4'(k + 7);
            tick();
        end
        chk("hold first done", done, 1);
        chk("hold first q", q, 2);
        chk("hold first r", r, 2);
        a = 4'd9; b = 4'd7;
        tick();
        chk("hold idle after done", busy, 0);
        chk("hold no redone", done, 0);
        a = 4'd11; b = 4'd4;
        tick();
        start = 1'b0;
        chk("hold second accept", busy, 1);
        n = 0;
        while (done !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        chk("hold second latency", n, 4);
        chk("hold second q", q, 2);
        chk("hold second r", r, 3);
        tick();

        // abort two cycles into 14/5
        a = 4'd14; b = 4'd5; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort q", q, 0);
        chk("abort r", r, 0);
        chk("abort busy", busy, 0);
        chk("abort done", done, 0);
        chk("abort dbz", dbz, 0);
        n = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) n++;
        end
        chk("abort stays idle", n, 0);
        do_div(4'd14, 4'd5, "14/5 fresh");

        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                do_div(4'(ai), 4'(bi), $sformatf("ex %0d/%0d", ai, bi));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
